arm_mc_ctrl: RTL and testbench
==============================

# arm_mc_ctrl

Multi-cycle controller for the ARM-subset RSA core: the parametrised successor of the single-cycle control/condition pair. It sequences each instruction through a state machine with configurable memory wait states, a registered NZCV flag store and latched condition result, a start/halt handshake, and an optional undefined-instruction trap. It sits beside the multi-cycle datapath and drives that datapath's enables and muxes from the instruction register contents and the ALU flags.

## Interface
- ALUC_W, 3: ALUControl width.
- MEM_WAIT, 0: extra wait cycles for each instruction fetch and each data memory access (0..15).
- HALT_INSTR, 32'hEF00_0000: encoding that halts the core when decoded.
- UNDEF_HALT, 1: 1 = unsupported op/cmd halts the core; 0 = treated as a NOP.

- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high.
- start  in  1  begins execution from IDLE.
- Instr  in  32  instruction register contents.
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  0 = PC, 1 = ALU result register as memory address.
- MemWrite  out  1  data memory write strobe.
- IRWrite  out  1  instruction register enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  out  1  0 = RD1, 1 = PC.
- ALUSrcB  out  2  00 RD2, 01 ExtImm, 10 constant 4.
- ImmSrc  out  2  equals Instr[27:26].
- RegSrc  out  2  {op==10, op==01}.
- ALUControl  out  ALUC_W  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MOV.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, HALT.
- IDLE: start=1 -> FETCH. Otherwise stay.
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10. The state holds MEM_WAIT+1 cycles, counted by a wait counter. IRWrite and PCWrite pulse only in the last cycle. Then -> DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10.
  - Latches cond_q = condition check of Instr[31:28] against the registered flags. All 15 ARM codes EQ..AL are supported; 1111 evaluates false.
  - Instr==HALT_INSTR -> HALT.
  - Otherwise dispatch on op = Instr[27:26]: 01 -> MEMADR; 10 -> BRANCH; 00 with Instr[25]=0 -> EXECR, Instr[25]=1 -> EXECI.
  - op=11, or DP cmd outside {0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR, 1101 MOV, 1010 CMP}, is undefined: -> HALT if UNDEF_HALT, else -> FETCH.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Instr[20]=1 (L) -> MEMRD, else -> MEMWR.
- MEMRD: AdrSrc=1, ResultSrc=00. Holds MEM_WAIT+1 cycles, then -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=cond_q. -> FETCH.
- MEMWR: AdrSrc=1, ResultSrc=00. MemWrite=cond_q in the last wait cycle only. -> FETCH.
- EXECR: ALUSrcA=0, ALUSrcB=00, ALUControl from cmd (CMP uses SUB).
- EXECI: as EXECR but ALUSrcB=01.
- From EXECR/EXECI: CMP -> FETCH; otherwise -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=cond_q. -> FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=cond_q. -> FETCH.
- R15 destination: in MEMWB or ALUWB with Instr[15:12]==1111, PCWrite=cond_q also asserts.
- Flags register, updated on the edge ending EXECR/EXECI, only when cond_q=1 and Instr[20] (S) =1, or when cmd=CMP:
  - NZ always update.
  - CV update only for ADD/SUB/CMP.
- Outputs not listed for a state are 0. ALUControl defaults to 000.
- HALT: all strobes 0, halted=1. Only reset exits HALT; start is ignored.

## Timing
- Reset (synchronous, wins over everything): state=IDLE, flags=0000, cond_q=0, wait counter=0, every output 0.
- Cycles per instruction with W=MEM_WAIT, from FETCH entry to the next FETCH entry:
  - DP: 4+W (CMP 3+W).
  - LDR: 5+2W.
  - STR: 4+2W.
  - B: 3+W.
- Condition latched in DECODE: an instruction's own flag update does not affect its own write-back gating.
- start high during busy is ignored.
- Reset mid-access abandons it; no MemWrite/RegWrite/PCWrite asserts in the reset cycle.

## Test plan
- Reset, then start pulse with MEM_WAIT=0 and Instr=E2810005 (ADD R0,R1,#5) -> FETCH, DECODE, EXECI, ALUWB; RegWrite=1 and ALUSrcB=01 in EXECI/ALUWB as specified; 4 cycles.
- MEM_WAIT=2, LDR E5912000 -> IRWrite/PCWrite only on the 3rd FETCH cycle; MEMRD lasts 3 cycles; RegWrite=1 with ResultSrc=01 in MEMWB; total 9 cycles.
- CMP E3500000 with operand zero (ALUFlags=0100), then BEQ 0A000002 -> flags Z=1 after EXECI; PCWrite=1 in BRANCH. Repeat with ALUFlags=0000 -> PCWrite=0.
- STR with cond NE (15812000) while Z=1 -> MemWrite stays 0 for the whole MEMWR state; the FSM still returns to FETCH.
- Instr=EF000000 -> HALT with halted=1, busy=0; start held high for 5 cycles -> state unchanged; reset -> IDLE.
- UNDEF_HALT=0 with op=11 -> DECODE then FETCH, no writes. UNDEF_HALT=1 -> HALT.

Source files
------------

// File: rtl/arm_mc_ctrl.sv
// Multi-cycle control FSM for the ARM-subset RSA core: sequences fetch/decode/execute
// with memory wait states, holds the NZCV flags and the latched condition result.
module arm_mc_ctrl #(
    parameter int          ALUC_W     = 3,
    parameter int          MEM_WAIT   = 0,
    parameter logic [31:0] HALT_INSTR = 32'hEF00_0000,
    parameter bit          UNDEF_HALT = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       Instr,
    input  logic [3:0]        ALUFlags,
    output logic              PCWrite,
    output logic              AdrSrc,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic              RegWrite,
    output logic [1:0]        ResultSrc,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ImmSrc,
    output logic [1:0]        RegSrc,
    output logic [ALUC_W-1:0] ALUControl,
    output logic              busy,
    output logic              halted
);

    localparam logic [3:0] S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,
                           S_MEMADR = 4'd3,  S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,
                           S_MEMWR  = 4'd6,  S_EXECR  = 4'd7,  S_EXECI  = 4'd8,
                           S_ALUWB  = 4'd9,  S_BRANCH = 4'd10, S_HALT   = 4'd11;

    logic [3:0] state, state_nx;
    logic [3:0] wcnt;
    logic [3:0] flags_q;
    logic       cond_q;
    logic [1:0] op;
    logic [3:0] cmd;
    logic       cmd_ok, is_cmp, is_arith, wlast, in_wait, in_exec, rd_pc;
    logic [2:0] dp_aluc;
    logic       unused_instr;

    assign op           = Instr[27:26];
    assign cmd          = Instr[24:21];
    assign wlast        = (wcnt == 4'(MEM_WAIT));
    assign in_wait      = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign in_exec      = (state == S_EXECR) || (state == S_EXECI);
    assign rd_pc        = (Instr[15:12] == 4'b1111);
    assign unused_instr = ^{Instr[19:16], Instr[11:0]};

    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'b0000: cond_eval = z;
            4'b0001: cond_eval = !z;
            4'b0010: cond_eval = cy;
            4'b0011: cond_eval = !cy;
            4'b0100: cond_eval = n;
            4'b0101: cond_eval = !n;
            4'b0110: cond_eval = v;
            4'b0111: cond_eval = !v;
            4'b1000: cond_eval = cy && !z;
            4'b1001: cond_eval = !cy || z;
            4'b1010: cond_eval = (n == v);
            4'b1011: cond_eval = (n != v);
            4'b1100: cond_eval = !z && (n == v);
            4'b1101: cond_eval = z || (n != v);
            4'b1110: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    always_comb begin
        cmd_ok   = 1'b1;
        is_cmp   = 1'b0;
        is_arith = 1'b0;
        dp_aluc  = 3'b000;
        case (cmd)
            4'b0100: is_arith = 1'b1;
            4'b0010: begin dp_aluc = 3'b001; is_arith = 1'b1; end
            4'b0000: dp_aluc = 3'b010;
            4'b1100: dp_aluc = 3'b011;
            4'b0001: dp_aluc = 3'b100;
            4'b1101: dp_aluc = 3'b101;
            4'b1010: begin dp_aluc = 3'b001; is_arith = 1'b1; is_cmp = 1'b1; end
            default: cmd_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_FETCH;
            S_FETCH:  if (wlast) state_nx = S_DECODE;
            S_DECODE: begin
                if (Instr == HALT_INSTR)
                    state_nx = S_HALT;
                else if (op == 2'b01)
                    state_nx = S_MEMADR;
                else if (op == 2'b10)
                    state_nx = S_BRANCH;
                else if (op == 2'b00 && cmd_ok)
                    state_nx = Instr[25] ? S_EXECI : S_EXECR;
                else
                    state_nx = UNDEF_HALT ? S_HALT : S_FETCH;
            end
            S_MEMADR: state_nx = Instr[20] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (wlast) state_nx = S_MEMWB;
            S_MEMWR:  if (wlast) state_nx = S_FETCH;
            S_EXECR,
            S_EXECI:  state_nx = is_cmp ? S_FETCH : S_ALUWB;
            S_MEMWB,
            S_ALUWB,
            S_BRANCH: state_nx = S_FETCH;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            wcnt    <= 4'd0;
            flags_q <= 4'b0000;
            cond_q  <= 1'b0;
        end else begin
            state <= state_nx;
            wcnt  <= (in_wait && !wlast) ? wcnt + 4'd1 : 4'd0;
            if (state == S_DECODE)
                cond_q <= cond_eval(Instr[31:28], flags_q);
            // CMP always writes flags; other DP ops only when S is set and the condition held
            if (in_exec && ((cond_q && Instr[20]) || is_cmp)) begin
                flags_q[3:2] <= ALUFlags[3:2];
                if (is_arith)
                    flags_q[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = '0;
        ImmSrc     = op;
        RegSrc     = {op == 2'b10, op == 2'b01};
        busy       = (state != S_IDLE) && (state != S_HALT);
        halted     = (state == S_HALT);
        case (state)
            S_FETCH: begin
                ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
                IRWrite = wlast; PCWrite = wlast;
            end
            S_DECODE: begin
                ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01; RegWrite = cond_q; PCWrite = cond_q && rd_pc;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1; MemWrite = cond_q && wlast;
            end
            S_EXECR:  ALUControl = ALUC_W'(dp_aluc);
            S_EXECI: begin
                ALUSrcB = 2'b01; ALUControl = ALUC_W'(dp_aluc);
            end
            S_ALUWB: begin
                RegWrite = cond_q; PCWrite = cond_q && rd_pc;
            end
            S_BRANCH: begin
                ALUSrcB = 2'b01; ResultSrc = 2'b10; PCWrite = cond_q;
            end
            default: ;
        endcase
        // reset abandons any access in flight, so nothing may strobe this cycle
        if (reset) begin
            PCWrite = 1'b0; AdrSrc = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
            RegWrite = 1'b0; ResultSrc = 2'b00; ALUSrcA = 1'b0; ALUSrcB = 2'b00;
            ImmSrc = 2'b00; RegSrc = 2'b00; ALUControl = '0; busy = 1'b0; halted = 1'b0;
        end
    end

endmodule

// File: tb/tb_arm_mc_ctrl.sv
// Directed bench for arm_mc_ctrl: three instances (W=0 trap, W=2, W=0 no-trap)
// share the same stimulus; each step checks the instance it targets.
module tb_arm_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;

    logic       pcw [3], adr [3], mw [3], irw [3], rw [3], alua [3], busy [3], hlt [3];
    logic [1:0] rs [3], asb [3], imm [3], rsrc [3];
    logic [2:0] aluc [3];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    arm_mc_ctrl #(.ALUC_W(3), .MEM_WAIT(0), .HALT_INSTR(32'hEF00_0000), .UNDEF_HALT(1'b1)) u0 (
        .clk(clk), .reset(reset), .start(start), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(pcw[0]), .AdrSrc(adr[0]), .MemWrite(mw[0]), .IRWrite(irw[0]),
        .RegWrite(rw[0]), .ResultSrc(rs[0]), .ALUSrcA(alua[0]), .ALUSrcB(asb[0]),
        .ImmSrc(imm[0]), .RegSrc(rsrc[0]), .ALUControl(aluc[0]), .busy(busy[0]), .halted(hlt[0]));

    arm_mc_ctrl #(.ALUC_W(3), .MEM_WAIT(2), .HALT_INSTR(32'hEF00_0000), .UNDEF_HALT(1'b1)) u2 (
        .clk(clk), .reset(reset), .start(start), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(pcw[1]), .AdrSrc(adr[1]), .MemWrite(mw[1]), .IRWrite(irw[1]),
        .RegWrite(rw[1]), .ResultSrc(rs[1]), .ALUSrcA(alua[1]), .ALUSrcB(asb[1]),
        .ImmSrc(imm[1]), .RegSrc(rsrc[1]), .ALUControl(aluc[1]), .busy(busy[1]), .halted(hlt[1]));

    arm_mc_ctrl #(.ALUC_W(3), .MEM_WAIT(0), .HALT_INSTR(32'hEF00_0000), .UNDEF_HALT(1'b0)) un (
        .clk(clk), .reset(reset), .start(start), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(pcw[2]), .AdrSrc(adr[2]), .MemWrite(mw[2]), .IRWrite(irw[2]),
        .RegWrite(rw[2]), .ResultSrc(rs[2]), .ALUSrcA(alua[2]), .ALUSrcB(asb[2]),
        .ImmSrc(imm[2]), .RegSrc(rsrc[2]), .ALUControl(aluc[2]), .busy(busy[2]), .halted(hlt[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; Instr = 32'h0; ALUFlags = 4'h0;
        tick();
        chk("rst_busy", 32'(busy[0]), 0);
        chk("rst_halted", 32'(hlt[0]), 0);
        chk("rst_pcw", 32'(pcw[0]), 0);
        chk("rst_irw", 32'(irw[0]), 0);

        // ADD R0,R1,#5 at W=0: FETCH DECODE EXECI ALUWB
        reset = 1'b0; Instr = 32'hE281_0005; start = 1'b1;
        tick(); start = 1'b0;
        chk("add_f_irw", 32'(irw[0]), 1);
        chk("add_f_pcw", 32'(pcw[0]), 1);
        chk("add_f_asb", 32'(asb[0]), 2);
        chk("add_f_busy", 32'(busy[0]), 1);
        tick();
        chk("add_d_irw", 32'(irw[0]), 0);
        chk("add_d_asb", 32'(asb[0]), 2);
        tick();
        chk("add_ei_asb", 32'(asb[0]), 1);
        chk("add_ei_alua", 32'(alua[0]), 0);
        chk("add_ei_aluc", 32'(aluc[0]), 0);
        tick();
        chk("add_wb_rw", 32'(rw[0]), 1);
        chk("add_wb_rs", 32'(rs[0]), 0);
        tick();
        chk("add_cpi4_irw", 32'(irw[0]), 1);
        tick(); tick(); tick();
        chk("add_wb2_rw", 32'(rw[0]), 1);
        reset = 1'b1; #1;
        chk("rstmid_rw", 32'(rw[0]), 0);
        chk("rstmid_busy", 32'(busy[0]), 0);
        tick(); reset = 1'b0;

        // LDR at W=2 on u2: 3 FETCH, DECODE, MEMADR, 3 MEMRD, MEMWB = 9
        do_reset();
        Instr = 32'hE591_2000; start = 1'b1;
        tick(); start = 1'b0;
        chk("ldr_f1_irw", 32'(irw[1]), 0);
        tick();
        chk("ldr_f2_irw", 32'(irw[1]), 0);
        chk("ldr_f2_pcw", 32'(pcw[1]), 0);
        tick();
        chk("ldr_f3_irw", 32'(irw[1]), 1);
        chk("ldr_f3_pcw", 32'(pcw[1]), 1);
        tick();
        chk("ldr_d_imm", 32'(imm[1]), 1);
        chk("ldr_d_rsrc", 32'(rsrc[1]), 1);
        tick();
        chk("ldr_ma_asb", 32'(asb[1]), 1);
        tick();
        chk("ldr_rd1_adr", 32'(adr[1]), 1);
        tick(); tick();
        chk("ldr_rd3_adr", 32'(adr[1]), 1);
        chk("ldr_rd3_rw", 32'(rw[1]), 0);
        tick();
        chk("ldr_wb_rw", 32'(rw[1]), 1);
        chk("ldr_wb_rs", 32'(rs[1]), 1);
        tick();
        chk("ldr_cpi9_busy", 32'(busy[1]), 1);
        chk("ldr_cpi9_irw", 32'(irw[1]), 0);
        chk("ldr_cpi9_asb", 32'(asb[1]), 2);

        // CMP R0,#0 with Z from ALU, then BEQ taken
        do_reset();
        Instr = 32'hE350_0000; ALUFlags = 4'b0100; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        tick();
        chk("cmp_ei_aluc", 32'(aluc[0]), 1);
        tick();
        chk("cmp_cpi3_irw", 32'(irw[0]), 1);
        chk("cmp_cpi3_rw", 32'(rw[0]), 0);
        Instr = 32'h0A00_0002;
        tick(); tick();
        chk("beq_t_pcw", 32'(pcw[0]), 1);
        chk("beq_t_rs", 32'(rs[0]), 2);
        chk("beq_t_asb", 32'(asb[0]), 1);
        tick();
        // CMP with Z clear, then BEQ not taken
        Instr = 32'hE350_0000; ALUFlags = 4'b0000;
        tick(); tick(); tick();
        Instr = 32'h0A00_0002;
        tick(); tick();
        chk("beq_nt_pcw", 32'(pcw[0]), 0);
        chk("beq_nt_busy", 32'(busy[0]), 1);
        tick();

        // set Z, then STRNE suppressed and STR AL performed
        Instr = 32'hE350_0000; ALUFlags = 4'b0100;
        tick(); tick(); tick();
        Instr = 32'h1581_2000;
        tick(); tick(); tick();
        chk("strne_mw", 32'(mw[0]), 0);
        chk("strne_adr", 32'(adr[0]), 1);
        tick();
        chk("strne_ret_irw", 32'(irw[0]), 1);
        Instr = 32'hE581_2000;
        tick(); tick(); tick();
        chk("stral_mw", 32'(mw[0]), 1);
        tick();
        chk("stral_ret_irw", 32'(irw[0]), 1);

        // halt instruction; start ignored while halted; reset releases
        Instr = 32'hEF00_0000;
        tick(); tick();
        chk("halt_halted", 32'(hlt[0]), 1);
        chk("halt_busy", 32'(busy[0]), 0);
        chk("halt_pcw", 32'(pcw[0]), 0);
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("halt_hold", 32'(hlt[0]), 1);
        end
        start = 1'b0; reset = 1'b1;
        tick();
        chk("halt_rst_halted", 32'(hlt[0]), 0);
        reset = 1'b0;
        tick();
        chk("halt_idle_busy", 32'(busy[0]), 0);
        chk("halt_idle_halted", 32'(hlt[0]), 0);

        // op=11 undefined: trap on u0, NOP on un
        do_reset();
        Instr = 32'hEC00_0000; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        chk("undef_d_rw", 32'(rw[2]), 0);
        chk("undef_d_mw", 32'(mw[2]), 0);
        tick();
        chk("undef_nop_irw", 32'(irw[2]), 1);
        chk("undef_nop_halted", 32'(hlt[2]), 0);
        chk("undef_trap_halted", 32'(hlt[0]), 1);
        Instr = 32'hE0A0_0000;
        tick(); tick();
        chk("undefcmd_nop_irw", 32'(irw[2]), 1);
        chk("undefcmd_nop_busy", 32'(busy[2]), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
